// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin FIFO write arbiter.
// Also used by the testbench so that both sides agree on the defaults.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    // An index into N requesters needs at least one bit, even when N is 1 or 2.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side streams plus the shared FIFO write port, bundled for the arbiter.
// The master modport is the arbiter; the slave modport is the producers/FIFO side.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
);

    localparam int ID_W = idWidth(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_wr_data;
    logic                    fifo_full;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;

    modport master (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_wr_en,
        output fifo_wr_data,
        output grant_id,
        output busy
    );

    modport slave (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_wr_data,
        input  grant_id,
        input  busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority encoder: returns the first requesting index at or after ptr_i,
// wrapping modulo N so that non-power-of-two requester counts rotate correctly.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N  = DEF_N_REQ,
    parameter int PW = idWidth(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] pick_o,
    output logic          any_o
);

    logic [PW-1:0] idx;

    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[idx]) begin
                pick_o = idx;
                any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers,
// granting one owner at a time for at most MAX_BURST beats and honouring fifo_full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rstn,
    fifo_wr_arbiter_if.master bus
);

    localparam int ID_W   = idWidth(N_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0]   pick;
    logic              any_req;
    logic              owner_valid;
    logic [DATA_W-1:0] owner_data;
    logic              beat;
    logic [N_REQ-1:0]  ready;

    rr_picker #(
        .N  (N_REQ),
        .PW (ID_W)
    ) u_picker (
        .req_i  (bus.req_valid),
        .ptr_i  (rr_ptr_q),
        .pick_o (pick),
        .any_o  (any_req)
    );

    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == ID_W'(i)) begin
                owner_valid = bus.req_valid[i];
                owner_data  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // fifo_full gates the write strobe combinationally so a full FIFO is never written.
    always_comb begin
        beat  = (state_q == GRANT) && owner_valid && !bus.fifo_full;
        ready = '0;
        if ((state_q == GRANT) && !bus.fifo_full) begin
            ready[owner_q] = 1'b1;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.fifo_wr_en   = beat;
    assign bus.fifo_wr_data = beat ? owner_data : '0;
    assign bus.grant_id     = owner_q;
    assign bus.busy         = (state_q == GRANT);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!owner_valid || (beat && (beat_cnt_q == LAST_BEAT))) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rstn) $onehot0(bus.req_ready));
    assert property (@(posedge clk) disable iff (!rstn) !(bus.fifo_wr_en && bus.fifo_full));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random-stress bench for fifo_wr_arbiter with 4 requesters, 8-bit data
// and bursts of 4; expected grants and data are worked out by hand or by a small scoreboard.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NR = DEF_N_REQ;
    localparam int DW = DEF_DATA_W;
    localparam int MB = DEF_MAX_BURST;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] pend;
    logic [5:0] seqArr [4];
    logic [5:0] expSeq [4];
    int         beatsInGrant;

    fifo_wr_arbiter_if #(.N_REQ(NR), .DATA_W(DW)) bus ();

    fifo_wr_arbiter #(
        .N_REQ     (NR),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkGrant(input string tag, input logic busyExp, input logic [1:0] idExp,
                              input logic wrExp, input logic [7:0] dataExp, input logic [3:0] readyExp);
        checkOutput({tag, ".busy"},  32'(bus.busy),         32'(busyExp));
        checkOutput({tag, ".id"},    32'(bus.grant_id),     32'(idExp));
        checkOutput({tag, ".wr"},    32'(bus.fifo_wr_en),   32'(wrExp));
        checkOutput({tag, ".data"},  32'(bus.fifo_wr_data), 32'(dataExp));
        checkOutput({tag, ".ready"}, 32'(bus.req_ready),    32'(readyExp));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data, input logic full);
        @(negedge clk);
        bus.req_valid = valid;
        bus.req_data  = data;
        bus.fifo_full = full;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rstn          = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    function automatic logic [31:0] slot(input int i, input logic [7:0] d);
        return {24'b0, d} << (8 * i);
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] allData;
        logic [31:0] v02;
        logic [31:0] sData;
        logic        sFull;
        int          prevId;
        int          id;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;

        @(negedge clk);
        #1;
        checkGrant("reset", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        rstn = 1'b1;

        // Single requester 2, six words, burst limit splits them 4 + 2.
        applyStimulus(4'b0100, slot(2, 8'h10), 1'b0);
        checkGrant("t1.arb", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0100, slot(2, 8'(8'h10 + k)), 1'b0);
            checkGrant("t1.beat", 1'b1, 2'd2, 1'b1, 8'(8'h10 + k), 4'b0100);
        end
        applyStimulus(4'b0100, slot(2, 8'h14), 1'b0);
        checkGrant("t1.bubble", 1'b0, 2'd2, 1'b0, 8'h00, 4'b0000);
        applyStimulus(4'b0100, slot(2, 8'h14), 1'b0);
        checkGrant("t1.regrant", 1'b1, 2'd2, 1'b1, 8'h14, 4'b0100);
        applyStimulus(4'b0100, slot(2, 8'h15), 1'b0);
        checkGrant("t1.last", 1'b1, 2'd2, 1'b1, 8'h15, 4'b0100);
        applyStimulus(4'b0000, 32'h0, 1'b0);
        checkGrant("t1.drop", 1'b1, 2'd2, 1'b0, 8'h00, 4'b0100);
        applyStimulus(4'b0000, 32'h0, 1'b0);
        checkGrant("t1.idle", 1'b0, 2'd2, 1'b0, 8'h00, 4'b0000);

        // All four valid after reset: grants 0,1,2,3,0 of four beats, one bubble between.
        doReset();
        allData = slot(0, 8'h40) | slot(1, 8'h41) | slot(2, 8'h42) | slot(3, 8'h43);
        prevId  = 0;
        for (int g = 0; g < 5; g++) begin
            id = g % 4;
            applyStimulus(4'b1111, allData, 1'b0);
            checkGrant("t2.gap", 1'b0, 2'(prevId), 1'b0, 8'h00, 4'b0000);
            for (int b = 0; b < 4; b++) begin
                applyStimulus(4'b1111, allData, 1'b0);
                checkGrant("t2.beat", 1'b1, 2'(id), 1'b1, 8'(8'h40 + id), 4'(1 << id));
            end
            prevId = id;
        end

        // Requester 1 stalls three cycles on full mid-burst and still gets four beats.
        applyStimulus(4'b0010, slot(1, 8'h51), 1'b0);
        checkGrant("t3.arb", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        applyStimulus(4'b0010, slot(1, 8'h51), 1'b0);
        checkGrant("t3.b1", 1'b1, 2'd1, 1'b1, 8'h51, 4'b0010);
        applyStimulus(4'b0010, slot(1, 8'h52), 1'b0);
        checkGrant("t3.b2", 1'b1, 2'd1, 1'b1, 8'h52, 4'b0010);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(4'b0010, slot(1, 8'h53), 1'b1);
            checkGrant("t3.stall", 1'b1, 2'd1, 1'b0, 8'h00, 4'b0000);
        end
        applyStimulus(4'b0010, slot(1, 8'h53), 1'b0);
        checkGrant("t3.b3", 1'b1, 2'd1, 1'b1, 8'h53, 4'b0010);
        applyStimulus(4'b0010, slot(1, 8'h54), 1'b0);
        checkGrant("t3.b4", 1'b1, 2'd1, 1'b1, 8'h54, 4'b0010);

        // Requester 3 drops valid after two beats; pointer wraps so 0 beats 2.
        applyStimulus(4'b1000, slot(3, 8'h61), 1'b0);
        checkGrant("t3.end", 1'b0, 2'd1, 1'b0, 8'h00, 4'b0000);
        applyStimulus(4'b1000, slot(3, 8'h61), 1'b0);
        checkGrant("t4.b1", 1'b1, 2'd3, 1'b1, 8'h61, 4'b1000);
        applyStimulus(4'b1000, slot(3, 8'h62), 1'b0);
        checkGrant("t4.b2", 1'b1, 2'd3, 1'b1, 8'h62, 4'b1000);
        v02 = slot(0, 8'h70) | slot(2, 8'h72);
        applyStimulus(4'b0101, v02, 1'b0);
        checkGrant("t4.drop", 1'b1, 2'd3, 1'b0, 8'h00, 4'b1000);
        applyStimulus(4'b0101, v02, 1'b0);
        checkGrant("t4.idle", 1'b0, 2'd3, 1'b0, 8'h00, 4'b0000);
        applyStimulus(4'b0101, v02, 1'b0);
        checkGrant("t4.wrap", 1'b1, 2'd0, 1'b1, 8'h70, 4'b0001);

        // Requester 2 granted with pointer at 1, then reset lands during its second beat.
        applyStimulus(4'b0100, slot(2, 8'h72), 1'b0);
        checkGrant("t5.drop0", 1'b1, 2'd0, 1'b0, 8'h00, 4'b0001);
        applyStimulus(4'b0100, slot(2, 8'h72), 1'b0);
        checkGrant("t5.idle", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        applyStimulus(4'b0100, slot(2, 8'h72), 1'b0);
        checkGrant("t5.b1", 1'b1, 2'd2, 1'b1, 8'h72, 4'b0100);
        applyStimulus(4'b0100, slot(2, 8'h73), 1'b0);
        checkGrant("t5.b2", 1'b1, 2'd2, 1'b1, 8'h73, 4'b0100);
        #2;
        rstn = 1'b0;
        #1;
        checkGrant("t5.rst", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        applyStimulus(4'b0101, slot(0, 8'h80) | slot(2, 8'h82), 1'b0);
        checkGrant("t5.hold", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        rstn = 1'b1;
        applyStimulus(4'b0101, slot(0, 8'h80) | slot(2, 8'h82), 1'b0);
        checkGrant("t5.first", 1'b1, 2'd0, 1'b1, 8'h80, 4'b0001);

        // Random stress: each producer sends {id, sequence}; the scoreboard expects per-id order.
        doReset();
        pend         = '0;
        beatsInGrant = 0;
        for (int i = 0; i < 4; i++) begin
            seqArr[i] = '0;
            expSeq[i] = '0;
        end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            sData = '0;
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom_range(1) == 1)) pend[i] = 1'b1;
                sData = sData | slot(i, {2'(i), seqArr[i]});
            end
            sFull = ($urandom_range(3) == 0);
            applyStimulus(pend, sData, sFull);

            checkOutput("s.noWriteWhenFull", 32'(bus.fifo_wr_en & bus.fifo_full), 32'd0);
            checkOutput("s.readyOneHot", 32'($onehot0(bus.req_ready)), 32'd1);
            if (!bus.busy) beatsInGrant = 0;
            if (bus.fifo_wr_en) begin
                id = int'(bus.fifo_wr_data[7:6]);
                checkOutput("s.order", 32'(bus.fifo_wr_data[5:0]), 32'(expSeq[id]));
                checkOutput("s.owner", 32'(bus.grant_id), 32'(id));
                checkOutput("s.readyOwner", 32'(bus.req_ready), 32'(1 << id));
                expSeq[id]   = expSeq[id] + 6'd1;
                beatsInGrant = beatsInGrant + 1;
                checkOutput("s.burstLen", 32'(beatsInGrant <= MB), 32'd1);
            end else begin
                checkOutput("s.dataZero", 32'(bus.fifo_wr_data), 32'd0);
            end

            for (int i = 0; i < 4; i++) begin
                if (pend[i] && bus.req_ready[i]) begin
                    seqArr[i] = seqArr[i] + 6'd1;
                    pend[i]   = 1'b0;
                end else if (pend[i] && ($urandom_range(15) == 0)) begin
                    pend[i] = 1'b0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one synchronous FIFO write port among `N_REQ` producers. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `wr_en`/`wr_data` while honouring `full`. It sits between the producer agents and the FIFO datapath, in place of a single driver on the FIFO interface.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `DATA_W`, 8: data width, matches FIFO data width.
- `MAX_BURST`, 4: maximum beats per grant, 1..255.
- `clk`  in  1  single clock, all logic on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N_REQ  per-requester data valid.
- `req_data`  in  N_REQ*DATA_W  packed data; requester i at bits [i*DATA_W +: DATA_W].
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_wr_data`  out  DATA_W  FIFO write data.
- `fifo_full`  in  1  FIFO full flag.
- `grant_id`  out  $clog2(N_REQ)  current or last owner index.
- `busy`  out  1  high while in GRANT.

## Operation
- States: IDLE, GRANT. Registers: `state`, `owner`, `rr_ptr`, `beat_cnt`.
- Reset values: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0. Outputs follow: grant_id=0, busy=0, fifo_wr_en=0, req_ready=0, fifo_wr_data=0.
- IDLE with any `req_valid`: pick the first valid index scanning rr_ptr, rr_ptr+1, … modulo N_REQ. owner <= pick, beat_cnt <= 0, go to GRANT.
- IDLE with no valid: stay in IDLE.
- In GRANT, outputs are combinational from registered state:
  - `req_ready[owner] = !fifo_full`.
  - `fifo_wr_en = req_valid[owner] & !fifo_full`.
  - `fifo_wr_data = req_data[owner]`, or 0 when fifo_wr_en=0.
- Beat: a cycle with fifo_wr_en=1. It increments beat_cnt.
- Leave GRANT for IDLE, with rr_ptr <= (owner+1) mod N_REQ, when either:
  - a beat occurs with beat_cnt == MAX_BURST-1, or
  - `req_valid[owner]` = 0 in that cycle.
- If both exit conditions hold in the same cycle, apply the single transition above.
- `fifo_full` while owner is valid: hold the grant. No beat, beat_cnt unchanged, no timeout.
- Non-owner valids are ignored until the next arbitration. Producers must hold data stable while valid and not ready.
- Reset asserted mid-burst: all registers return to reset values immediately. The in-flight beat is not written.
- Width: beat_cnt is $clog2(MAX_BURST+1) bits. rr_ptr wraps from N_REQ-1 to 0, including for non-power-of-2 N_REQ.

## Timing
- Arbitration latency: valid first sampled in IDLE at cycle t, grant at t+1, first write at t+1 if not full.
- Full burst from t+1 with no stalls: writes at t+1..t+MAX_BURST, IDLE at t+MAX_BURST+1, next grant at t+MAX_BURST+2. There is exactly one bubble cycle between grants.
- Owner drops valid at cycle k: no write at k, IDLE at k+1.
- `fifo_full` → `fifo_wr_en` is a zero-cycle combinational path. `busy` and `grant_id` are registered.
- Never more than one `req_ready` bit high. `fifo_wr_en` never high while `fifo_full`=1.

## Structure
- Package `fifo_arb_pkg`: `arb_state_e` {IDLE, GRANT} and default parameter constants, shared with the bench's monitor and scoreboard.
- Sub-module `rr_picker`: combinational rotate-priority encoder. Inputs req vector and rr_ptr; outputs pick index and any_req. Instantiated once in the FSM.

## Test plan
- Single requester 2 valid, 6 words 0x10..0x15, MAX_BURST=4, never full → writes 0x10..0x13 at t+1..t+4, IDLE at t+5, grant again at t+6, writes 0x14, 0x15.
- All four requesters valid continuously after reset → grant order 0, 1, 2, 3, 0; each grant exactly 4 beats; one idle cycle between grants.
- Requester 1 granted, `fifo_full` high for 3 cycles mid-burst → fifo_wr_en=0 and req_ready=0 for those cycles; burst resumes and still totals 4 beats; no data lost or duplicated.
- Requester 3 valid for 2 beats then drops valid → IDLE next cycle; rr_ptr=0 (wrap); requester 0 wins over requester 2 if both are valid.
- rstn pulled low during beat 2 of a burst → all outputs 0 asynchronously, rr_ptr=0. After release, requester 0 is granted first when valid.
- Random valid/full stress, 1000 cycles → scoreboard sees per-requester order preserved, no write while full, at most one ready bit high, at most MAX_BURST consecutive beats per owner.
